// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the ID/EX operand stage and its forwarding
// unit. Holds the ALU operation codes, the forward-select encoding, the
// default datapath widths and a small saturating-increment helper.
package cpu_pkg;

    // Default widths for the integer datapath.
    localparam int CPU_DATA_W = 32;
    localparam int CPU_REG_AW = 5;

    // ALU operation codes driven on alu_ctrl.
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_SRAI = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SLL  = 3'b011;
    localparam logic [2:0] ALU_MUL  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_XOR  = 3'b111;

    // Where a source operand is taken from.
    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // 32-bit counter increment that sticks at all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select-and-mux for one source register. Purely
// combinational: picks the youngest in-flight producer of the source
// register (EX/MEM before MEM/WB) and forces x0 to read as zero.
module fwd_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int REG_AW = CPU_REG_AW
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    input  logic              fwd_en,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] data
);

    fwd_sel_e sel;

    // Choose the operand source; EX/MEM holds the younger result so it wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        sel = FWD_RF;
        if (fwd_en && exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src_addr)) begin
            sel = FWD_EXMEM;
        end else if (fwd_en && memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src_addr)) begin
            sel = FWD_MEMWB;
        end
    end

    // Drive the selected value; x0 is hard-wired to zero whatever the inputs say.
    always_comb begin
        data = src_data;
        unique case (sel)
            FWD_EXMEM: data = exmem_result;
            FWD_MEMWB: data = memwb_result;
            default:   data = src_data;
        endcase
        if (src_addr == '0) begin
            data = '0;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register and ALU operand-select stage. Captures decoded
// fields, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, inserts
// one bubble on load-use, and holds under EX back-pressure.
// Optional performance counters are built when ID_EX_PERF_CNT_EN is defined.
module id_ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int REG_AW = CPU_REG_AW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [2:0]        alu_ctrl_i,
    input  logic              alu_src_i,
    input  logic              reg_write_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              flush_i,
    input  logic              ex_ready_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic              exmem_reg_write_i,
    input  logic              memwb_reg_write_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic [DATA_W-1:0] memwb_result_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data1_o,
    output logic [DATA_W-1:0] data2_o,
    output logic [2:0]        alu_ctrl_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [REG_AW-1:0] rd_addr_o,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]       bubble_cnt_o,
    output logic [31:0]       stall_cnt_o,
`endif
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o
);

    // Registered instruction fields.
    logic              valid_q;
    logic [REG_AW-1:0] rs1_addr_q;
    logic [REG_AW-1:0] rs2_addr_q;
    logic [REG_AW-1:0] rd_addr_q;
    logic [DATA_W-1:0] rs1_data_q;
    logic [DATA_W-1:0] rs2_data_q;
    logic [DATA_W-1:0] imm_q;
    logic [2:0]        alu_ctrl_q;
    logic              alu_src_q;
    logic              reg_write_q;
    logic              mem_read_q;
    logic              mem_write_q;
    // Forwarding is allowed only while the register values are as captured;
    // once a hold folds the forwarded values back in, the registers are final.
    logic              fwd_en_q;

    logic [DATA_W-1:0] fwd1_data;
    logic [DATA_W-1:0] fwd2_data;
    logic              hazard;

    // Load-use detection against the instruction waiting in ID; rs2 is compared
    // even for immediate forms to keep the check simple and safe.
    always_comb begin
        hazard = valid_q && mem_read_q && (rd_addr_q != '0) && valid_i &&
                 ((rd_addr_q == rs1_addr_i) || (rd_addr_q == rs2_addr_i));
    end

    assign ready_o = ex_ready_i && !hazard && !flush_i;

    fwd_unit #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rs1 (
        .src_addr        (rs1_addr_q),
        .src_data        (rs1_data_q),
        .fwd_en          (fwd_en_q),
        .exmem_rd        (exmem_rd_i),
        .exmem_reg_write (exmem_reg_write_i),
        .exmem_result    (exmem_result_i),
        .memwb_rd        (memwb_rd_i),
        .memwb_reg_write (memwb_reg_write_i),
        .memwb_result    (memwb_result_i),
        .data            (fwd1_data)
    );

    fwd_unit #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rs2 (
        .src_addr        (rs2_addr_q),
        .src_data        (rs2_data_q),
        .fwd_en          (fwd_en_q),
        .exmem_rd        (exmem_rd_i),
        .exmem_reg_write (exmem_reg_write_i),
        .exmem_result    (exmem_result_i),
        .memwb_rd        (memwb_rd_i),
        .memwb_reg_write (memwb_reg_write_i),
        .memwb_result    (memwb_result_i),
        .data            (fwd2_data)
    );

    // Pipeline register: flush, hold, bubble, capture, drain, in that priority.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q     <= 1'b0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            alu_ctrl_q  <= ALU_ADD;
            alu_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            fwd_en_q    <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (!ex_ready_i) begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            rs1_data_q <= fwd1_data;
            rs2_data_q <= fwd2_data;
            fwd_en_q   <= 1'b0;
        end else if (hazard) begin
            valid_q <= 1'b0;
        end else if (valid_i) begin
            valid_q     <= 1'b1;
            rs1_addr_q  <= rs1_addr_i;
            rs2_addr_q  <= rs2_addr_i;
            rd_addr_q   <= rd_addr_i;
            rs1_data_q  <= rs1_data_i;
            rs2_data_q  <= rs2_data_i;
            imm_q       <= imm_i;
            alu_ctrl_q  <= alu_ctrl_i;
            alu_src_q   <= alu_src_i;
            reg_write_q <= reg_write_i;
            mem_read_q  <= mem_read_i;
            mem_write_q <= mem_write_i;
            fwd_en_q    <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] stall_cnt_q;

    // Saturating counters for load-use bubbles and back-pressure stall cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (!flush_i && ex_ready_i && hazard) begin
                bubble_cnt_q <= sat_inc(bubble_cnt_q);
            end
            if (!ex_ready_i && valid_q) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;
`endif

    assign valid_o      = valid_q;
    assign data1_o      = fwd1_data;
    assign store_data_o = fwd2_data;
    assign data2_o      = alu_src_q ? imm_q : fwd2_data;
    assign alu_ctrl_o   = alu_ctrl_q;
    assign rd_addr_o    = rd_addr_q;
    assign reg_write_o  = valid_q && reg_write_q;
    assign mem_read_o   = valid_q && mem_read_q;
    assign mem_write_o  = valid_q && mem_write_q;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage directly upstream of the EX-stage ALU.
- Captures decoded instruction fields and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts one bubble; honours EX back-pressure from the multi-cycle multiplier.
- Drives the ALU operand 1, operand 2 and 3-bit control inputs.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-address width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  ID has an instruction.
- ready_o  out  1  stage accepts the ID instruction this cycle.
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  REG_AW  register addresses.
- rs1_data_i, rs2_data_i, imm_i  in  DATA_W  register-file reads and sign-extended immediate.
- alu_ctrl_i  in  3  ALU operation code.
- alu_src_i  in  1  1 = operand 2 is the immediate.
- reg_write_i, mem_read_i, mem_write_i  in  1  control bits.
- flush_i  in  1  kill the held and incoming instruction (branch taken).
- ex_ready_i  in  1  EX can consume this cycle.
- exmem_rd_i, memwb_rd_i  in  REG_AW  forwarding destinations.
- exmem_reg_write_i, memwb_reg_write_i  in  1  forwarding write enables.
- exmem_result_i, memwb_result_i  in  DATA_W  forwarding values.
- valid_o  out  1  EX instruction valid.
- data1_o, data2_o  out  DATA_W  ALU operands.
- alu_ctrl_o  out  3  ALU operation code.
- store_data_o  out  DATA_W  forwarded rs2 value for stores.
- rd_addr_o  out  REG_AW  destination register.
- reg_write_o, mem_read_o, mem_write_o  out  1  control bits, gated by valid_o.

Behaviour:
- Reset (rst_i low, asynchronous):
  - valid_o=0, every register cleared, alu_ctrl_o=3'b010 (ADD).
  - data1_o, data2_o and store_data_o are 0 and held at 0 until the first capture.
- Hazard, combinational:
  - hazard = valid_o & mem_read_o & (rd_addr_o!=0) & valid_i & (rd_addr_o==rs1_addr_i | rd_addr_o==rs2_addr_i).
  - rs2 is compared even when alu_src_i=1 (conservative).
- ready_o = ex_ready_i & ~hazard & ~flush_i.
- Per rising edge, priority order:
  1. flush_i: valid_o<=0.
  2. ~ex_ready_i: hold. The forwarded operand values are written back into the rs1/rs2 registers and the forward selects are cleared, so a later WB retirement cannot lose the data.
  3. hazard: valid_o<=0 (bubble); ID holds because ready_o=0.
  4. valid_i: capture all fields, valid_o<=1.
  5. Otherwise: valid_o<=0.
- Forwarding is a combinational mux on the registered rs1/rs2 values:
  - EX/MEM wins over MEM/WB.
  - A source is forwarded only if the write enable is set, rd!=0 and rd equals the source address.
  - x0 always reads 0.
- data2_o = alu_src ? imm : forwarded rs2. store_data_o = forwarded rs2 always.
- Latency: one cycle from ID acceptance to the ALU inputs. The load-use penalty is exactly one bubble.
- Simultaneous flush_i and hazard: flush wins, and ready_o=0 that cycle.
- Reset during a stall: everything clears, ready_o=1 after reset release.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- When defined:
  - adds outputs bubble_cnt_o[31:0] (counts hazard bubbles) and stall_cnt_o[31:0] (counts cycles with ~ex_ready_i & valid_o).
  - both counters saturate at 32'hFFFF_FFFF and clear on reset.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU code constants: AND=000, SRAI=001, ADD=010, SLL=011, MUL=100, SUB=110, XOR=111.
  - Forward-select enum: FWD_RF, FWD_EXMEM, FWD_MEMWB.
  - DATA_W and REG_AW defaults.
- One sub-module, fwd_unit: a purely combinational select-and-mux, instantiated once per source operand.

Test Plan:
- Reset mid-stream: assert rst_i low with valid_o=1 → valid_o=0 and alu_ctrl_o=010 immediately, without waiting for a clock edge.
- Forward priority: add x5 is in EX/MEM with result 7, x5 is in MEM/WB with value 3, then sub x6,x5,x5 → data1_o=data2_o=7.
- Load-use: lw x5 followed by add x7,x5,x1 → one cycle with ready_o=0, then valid_o=0; the next cycle memwb_result 0x1234 is forwarded to data1_o.
- Back-pressure: ex_ready_i=0 for 3 cycles while MEM/WB forwards 0xAA and then retires → data1_o stays 0xAA; with ID_EX_PERF_CNT_EN, stall_cnt_o=3.
- Flush together with hazard: flush_i=1 while a load-use hazard is pending → next cycle valid_o=0 and reg_write_o=0.
- x0 guard: EX/MEM has reg_write=1, rd=0, result 0xFFFF; the instruction reads x0 → data1_o=0.
